// File: rtl/dout_byte_streamer.sv
// dout_byte_streamer: word FIFO feeding an MSB-first valid/ready byte serializer
module dout_byte_streamer #(
  parameter int DATA_WID = 48,
  parameter int DEPTH    = 16,
  parameter int ADDR_WID = 4,
  parameter int CNT_WID  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_WID-1:0] din,
  input  logic                din_wr,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic                overflow,
  input  logic                clr_ovf,
  output logic [CNT_WID-1:0]  word_cnt
);
  localparam int NB = DATA_WID / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [DATA_WID-1:0] mem [DEPTH];
  logic [ADDR_WID-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WID:0]   count;
  logic [DATA_WID-1:0] shreg;
  logic [BW-1:0]       byte_idx;
  logic hs, word_done, wr, pop;
  assign fifo_full  = count == (ADDR_WID+1)'(DEPTH);
  assign fifo_empty = count == '0;
  assign wr         = din_wr && !fifo_full;
  assign hs         = tx_valid && tx_ready;
  assign word_done  = hs && byte_idx == BW'(NB - 1);
  // a finishing word pops its successor in the same cycle, so words stream without a bubble
  always_comb begin
    tx_valid = state == SEND;
    tx_data  = shreg[DATA_WID-1 -: 8];
    pop      = !fifo_empty && (state == IDLE || word_done);
    state_nx = pop ? SEND : word_done ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      shreg    <= '0;
      byte_idx <= '0;
      overflow <= 1'b0;
      word_cnt <= '0;
    end else begin
      state    <= state_nx;
      wr_ptr   <= wr ? wr_ptr + ADDR_WID'(1) : wr_ptr;
      rd_ptr   <= pop ? rd_ptr + ADDR_WID'(1) : rd_ptr;
      count    <= count + (ADDR_WID+1)'(wr) - (ADDR_WID+1)'(pop);
      shreg    <= pop ? mem[rd_ptr] : hs ? shreg << 8 : shreg;
      byte_idx <= pop ? '0 : hs ? byte_idx + BW'(1) : byte_idx;
      overflow <= (din_wr && fifo_full) || (overflow && !clr_ovf);
      word_cnt <= word_done ? word_cnt + CNT_WID'(1) : word_cnt;
    end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= din;
endmodule

// File: tb/tb_dout_byte_streamer.sv
// tb_dout_byte_streamer: scenario tasks checked against a word-queue-to-byte-stream model
module tb_dout_byte_streamer;
  localparam int DW = 48;
  localparam int NB = DW / 8;
  logic clk = 0, rst_n = 0, din_wr = 0, tx_ready = 0, clr_ovf = 0;
  logic tx_valid, fifo_full, fifo_empty, overflow;
  logic [DW-1:0] din = '0;
  logic [7:0] tx_data;
  logic [15:0] word_cnt;
  logic [7:0] got[$], exp_q[$];
  int checks = 0, errors = 0;
  int unsigned exp_cnt = 0;

  always #5 clk = ~clk;

  dout_byte_streamer dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_wr(din_wr),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .overflow(overflow),
    .clr_ovf(clr_ovf), .word_cnt(word_cnt)
  );

  // byte sink: records every accepted byte
  always @(negedge clk) if (rst_n && tx_valid && tx_ready) got.push_back(tx_data);

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // model: an accepted word becomes its bytes, most significant first
  task automatic expect_word(input logic [DW-1:0] w);
    for (int i = NB - 1; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
  endtask

  task automatic write_word(input logic [DW-1:0] w);
    din = w; din_wr = 1; tick(); din_wr = 0;
  endtask

  task automatic drain(input int lim);
    for (int i = 0; i < lim && (tx_valid || !fifo_empty); i++) tick();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx valid=%b data=%h want 0/00", tx_valid, tx_data); end
    checks++; if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin errors++; $display("FAIL reset_flags empty=%b full=%b want 1/0", fifo_empty, fifo_full); end
    checks++; if (overflow !== 1'b0 || word_cnt !== 16'd0) begin errors++; $display("FAIL reset_ovf_cnt ovf=%b cnt=%0d want 0/0", overflow, word_cnt); end
    #20 rst_n = 1;
    tick();
    checks++; if (tx_valid !== 1'b0 || fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_release valid=%b empty=%b want 0/1", tx_valid, fifo_empty); end
  endtask

  task automatic test_single();
    logic [DW-1:0] w = 48'h4900_1234_5600;
    got.delete(); exp_q.delete(); expect_word(w); tx_ready = 1;
    write_word(w);
    checks++; if (fifo_empty !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL single_edgeN empty=%b valid=%b want 0/0", fifo_empty, tx_valid); end
    tick();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h49) begin errors++; $display("FAIL single_edgeN1 valid=%b data=%h want 1/49", tx_valid, tx_data); end
    repeat (NB) tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_end valid=%b want 0", tx_valid); end
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL single_len got %0d want %0d", got.size(), exp_q.size()); end
    else for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL single_byte%0d got %h want %h", i, got[i], exp_q[i]); end
    end
    exp_cnt++;
    checks++; if (word_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL single_cnt got %0d want %0d", word_cnt, exp_cnt); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] w = 48'h4900_1234_5600;
    got.delete(); exp_q.delete(); expect_word(w); tx_ready = 1;
    write_word(w);
    repeat (3) tick();
    tx_ready = 0;
    checks++; if (tx_data !== 8'h12) begin errors++; $display("FAIL stall_pos got %h want 12", tx_data); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h12) begin errors++; $display("FAIL stall_hold%0d valid=%b data=%h want 1/12", k, tx_valid, tx_data); end
    end
    tx_ready = 1;
    drain(20);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL stall_timeout valid=%b want 0", tx_valid); end
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL stall_len got %0d want %0d", got.size(), exp_q.size()); end
    else for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL stall_byte%0d got %h want %h", i, got[i], exp_q[i]); end
    end
    exp_cnt++;
    checks++; if (word_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL stall_cnt got %0d want %0d", word_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    bit gap = 0;
    got.delete(); exp_q.delete(); tx_ready = 1;
    expect_word(48'h5109_AABB_CCDD); expect_word(48'h5112_1122_3344);
    write_word(48'h5109_AABB_CCDD);
    write_word(48'h5112_1122_3344);
    for (int k = 0; k < 2 * NB - 1; k++) begin
      if (tx_valid !== 1'b1) gap = 1;
      tick();
    end
    checks++; if (gap || tx_valid !== 1'b1) begin errors++; $display("FAIL b2b_gap gap=%b valid=%b want 0/1", gap, tx_valid); end
    tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_end valid=%b want 0", tx_valid); end
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL b2b_len got %0d want %0d", got.size(), exp_q.size()); end
    else for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", i, got[i], exp_q[i]); end
    end
    exp_cnt += 2;
    checks++; if (word_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL b2b_cnt got %0d want %0d", word_cnt, exp_cnt); end
  endtask

  // stalled sink: one word sits in the shifter, sixteen fill the FIFO, the next is dropped
  task automatic test_overflow();
    logic [DW-1:0] w;
    got.delete(); exp_q.delete(); tx_ready = 0;
    for (int k = 0; k < 17; k++) begin
      checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL ovf_early_full at write %0d full=%b want 0", k, fifo_full); end
      w = DW'({$urandom, $urandom});
      expect_word(w);
      write_word(w);
    end
    checks++; if (fifo_full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_full full=%b ovf=%b want 1/0", fifo_full, overflow); end
    write_word(DW'({$urandom, $urandom}));
    checks++; if (overflow !== 1'b1 || fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_drop ovf=%b full=%b want 1/1", overflow, fifo_full); end
    checks++; if (got.size() != 0) begin errors++; $display("FAIL ovf_nobytes got %0d want 0", got.size()); end
    clr_ovf = 1; tick(); clr_ovf = 0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", overflow); end
  endtask

  task automatic test_full_last_drop();
    tx_ready = 1;
    repeat (NB - 1) tick();
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL lastdrop_pre full=%b want 1", fifo_full); end
    din = DW'({$urandom, $urandom}); din_wr = 1; clr_ovf = 1;
    tick();
    din_wr = 0; clr_ovf = 0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL lastdrop_ovf got %b want 1", overflow); end
    checks++; if (fifo_full !== 1'b0 || tx_valid !== 1'b1) begin errors++; $display("FAIL lastdrop_count full=%b valid=%b want 0/1", fifo_full, tx_valid); end
    drain(17 * NB + 20);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL lastdrop_timeout valid=%b want 0", tx_valid); end
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL lastdrop_len got %0d want %0d", got.size(), exp_q.size()); end
    else for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL lastdrop_byte%0d got %h want %h", i, got[i], exp_q[i]); end
    end
    exp_cnt += 17;
    checks++; if (word_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL lastdrop_cnt got %0d want %0d", word_cnt, exp_cnt); end
    clr_ovf = 1; tick(); clr_ovf = 0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL lastdrop_clr got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid();
    got.delete(); exp_q.delete(); tx_ready = 1;
    for (int k = 0; k < 3; k++) write_word(DW'({$urandom, $urandom}));
    repeat (3) tick();
    checks++; if (got.size() != 4) begin errors++; $display("FAIL rstmid_pre bytes %0d want 4", got.size()); end
    rst_n = 0; #1;
    checks++; if (tx_valid !== 1'b0 || fifo_empty !== 1'b1 || word_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_async valid=%b empty=%b cnt=%0d want 0/1/0", tx_valid, fifo_empty, word_cnt); end
    exp_cnt = 0;
    #2 rst_n = 1;
    got.delete();
    repeat (10) tick();
    checks++; if (got.size() != 0 || fifo_empty !== 1'b1 || tx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_post bytes=%0d empty=%b valid=%b want 0/1/0", got.size(), fifo_empty, tx_valid); end
  endtask

  task automatic test_random();
    int sent = 0, gap = 0;
    logic [DW-1:0] w;
    got.delete(); exp_q.delete();
    for (int c = 0; c < 5000 && sent < 24; c++) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      if (gap == 0) begin
        w = DW'({$urandom, $urandom});
        din = w; din_wr = 1; expect_word(w); sent++;
        gap = $urandom_range(1, 20);
      end else begin
        din_wr = 0; gap--;
      end
      tick();
    end
    din_wr = 0; tx_ready = 1;
    drain(24 * NB + 50);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rand_timeout valid=%b want 0", tx_valid); end
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL rand_len got %0d want %0d", got.size(), exp_q.size()); end
    else for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d got %h want %h", i, got[i], exp_q[i]); end
    end
    exp_cnt += 24;
    checks++; if (word_cnt !== 16'(exp_cnt) || overflow !== 1'b0) begin errors++; $display("FAIL rand_cnt cnt=%0d ovf=%b want %0d/0", word_cnt, overflow, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_full_last_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
